// File: rtl/lfsr_seq_checker.sv
// Lock/flywheel monitor for a 4-bit maximal-length feedback shift counter.
// Tracks lock state, saturating mismatch count, sequence period and all-zero lock-up.
module lfsr_seq_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       data_in,
    input  logic             valid,
    input  logic             err_clr,
    output logic [3:0]       expected,
    output logic             locked,
    output logic             lost,
    output logic             stuck_zero,
    output logic [ERR_W-1:0] err_cnt,
    output logic [4:0]       period,
    output logic             period_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SYNC   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_LOST   = 2'd3;

    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [3:0]       LOSS_N  = 4'(LOSS_COUNT);
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] f_next(input logic [3:0] q);
        return {q[0] ^ q[1], q[3], q[2], q[1]};
    endfunction

    logic [1:0]       r_state;
    logic [3:0]       r_ref;
    logic [3:0]       r_anchor;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_miss_cnt;
    logic [4:0]       r_per_cnt;
    logic [4:0]       r_period;
    logic             r_per_vld;
    logic             r_stuck;
    logic [ERR_W-1:0] r_err;

    logic [3:0] w_next_ref;
    logic       w_match;
    logic       w_zero;
    logic       w_lock_miss;
    logic [3:0] w_match_inc;
    logic [3:0] w_miss_inc;
    logic [4:0] w_per_inc;

    assign w_next_ref  = f_next(r_ref);
    assign w_match     = (data_in == w_next_ref);
    assign w_zero      = (data_in == 4'd0);
    assign w_lock_miss = valid && (r_state == S_LOCKED) && !w_match;
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;
    assign w_per_inc   = (r_per_cnt == 5'd31) ? 5'd31 : r_per_cnt + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ref       <= 4'd0;
            r_anchor    <= 4'd0;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_per_cnt   <= 5'd0;
            r_period    <= 5'd0;
            r_per_vld   <= 1'b0;
            r_stuck     <= 1'b0;
            r_err       <= '0;
        end else begin
            r_per_vld <= 1'b0;

            // Clear has priority over a same-cycle mismatch.
            if (err_clr)
                r_err <= '0;
            else if (w_lock_miss && !(&r_err))
                r_err <= r_err + ERR_ONE;

            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        if (w_zero) begin
                            r_stuck <= 1'b1;
                        end else begin
                            r_ref       <= data_in;
                            r_match_cnt <= 4'd0;
                            r_state     <= S_SYNC;
                        end
                    end
                end
                S_SYNC: begin
                    if (valid) begin
                        if (w_zero) begin
                            r_stuck <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (w_match) begin
                            r_ref       <= data_in;
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == LOCK_N) begin
                                r_state    <= S_LOCKED;
                                r_anchor   <= data_in;
                                r_per_cnt  <= 5'd0;
                                r_miss_cnt <= 4'd0;
                            end
                        end else begin
                            r_ref       <= data_in;
                            r_match_cnt <= 4'd0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (valid) begin
                        if (w_match) begin
                            r_ref      <= data_in;
                            r_miss_cnt <= 4'd0;
                            if (data_in == r_anchor) begin
                                r_period  <= w_per_inc;
                                r_per_vld <= 1'b1;
                                r_per_cnt <= 5'd0;
                            end else begin
                                r_per_cnt <= w_per_inc;
                            end
                        end else begin
                            // Flywheel: advance the reference, ignore the bad sample.
                            r_ref      <= w_next_ref;
                            r_miss_cnt <= w_miss_inc;
                            r_per_cnt  <= w_per_inc;
                            if (w_miss_inc == LOSS_N)
                                r_state <= S_LOST;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign expected     = w_next_ref;
    assign locked       = (r_state == S_LOCKED);
    assign lost         = (r_state == S_LOST);
    assign stuck_zero   = r_stuck;
    assign err_cnt      = r_err;
    assign period       = r_period;
    assign period_valid = r_per_vld;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: acquisition, period, flywheel, loss,
// lock-up flag, gaps, error saturation/clear and async reset.
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       valid;
    logic       err_clr;
    logic [3:0] expected;
    logic       locked;
    logic       lost;
    logic       stuck_zero;
    logic [7:0] err_cnt;
    logic [4:0] period;
    logic       period_valid;

    int errors = 0;
    int checks = 0;
    int idx;

    // Correct counter cycle starting at 0001.
    logic [3:0] seq [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                             4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};

    lfsr_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
        .err_clr(err_clr), .expected(expected), .locked(locked), .lost(lost),
        .stuck_zero(stuck_zero), .err_cnt(err_cnt), .period(period),
        .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [3:0] d);
        data_in = d;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        valid   = 1'b0;
        data_in = 4'hC;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; valid = 1'b0; err_clr = 1'b0; data_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({locked, lost, stuck_zero, err_cnt, period, period_valid} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {locked, lost, stuck_zero, err_cnt, period, period_valid});
        end
        checks++;
        if (expected !== 4'h0) begin errors++; $display("FAIL reset_expected: got %h want 0", expected); end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_acquire;
        send(4'h1);
        send(4'h8);
        send(4'h4);
        send(4'h2);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL acquire_early: locked got %b want 0", locked); end
        send(4'h9);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL acquire_lock: locked got %b want 1", locked); end
        checks++;
        if (expected !== 4'hC) begin errors++; $display("FAIL acquire_expected: got %h want c", expected); end
        idx = 4;
    endtask

    task automatic test_period;
        for (int i = 0; i < 30; i++) begin
            idx = (idx + 1) % 15;
            send(seq[idx]);
            checks++;
            if (period_valid !== (idx == 4)) begin
                errors++;
                $display("FAIL period_valid[%0d]: got %b want %b", i, period_valid, idx == 4);
            end
            if (idx == 4) begin
                checks++;
                if (period !== 5'd15) begin errors++; $display("FAIL period_value[%0d]: got %0d want 15", i, period); end
            end
        end
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL period_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_flywheel;
        for (int i = 0; i < 15; i++) begin
            idx = (idx + 1) % 15;
            send((idx == 6) ? 4'h0 : seq[idx]);
            if (idx == 6) begin
                checks++;
                if ({err_cnt, locked, stuck_zero} !== {8'd1, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL flywheel_bad: err=%0d locked=%b stuck=%b want 1 1 0", err_cnt, locked, stuck_zero);
                end
            end
            if (idx == 7) begin
                checks++;
                if ({expected, err_cnt, locked} !== {4'h5, 8'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL flywheel_resume: exp=%h err=%0d locked=%b want 5 1 1", expected, err_cnt, locked);
                end
            end
        end
        checks++;
        if ({period_valid, period} !== {1'b1, 5'd15}) begin
            errors++;
            $display("FAIL flywheel_period: pv=%b period=%0d want 1 15", period_valid, period);
        end
    endtask

    task automatic test_loss;
        send(4'h7);
        send(4'h7);
        checks++;
        if ({locked, lost} !== 2'b10) begin errors++; $display("FAIL loss_two_miss: locked=%b lost=%b want 1 0", locked, lost); end
        send(4'h7);
        checks++;
        if ({locked, lost, err_cnt} !== {2'b01, 8'd4}) begin
            errors++;
            $display("FAIL loss_pulse: locked=%b lost=%b err=%0d want 0 1 4", locked, lost, err_cnt);
        end
        send(4'h0);  // arrives in the LOST cycle, must be dropped
        checks++;
        if ({locked, lost, stuck_zero} !== 3'b000) begin
            errors++;
            $display("FAIL loss_exit: locked=%b lost=%b stuck=%b want 0 0 0", locked, lost, stuck_zero);
        end
        send(4'hA);
        send(4'hD);
        send(4'hE);
        send(4'hF);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reacq_early: locked got %b want 0", locked); end
        send(4'h7);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL reacq_lock: locked got %b want 1", locked); end
    endtask

    task automatic test_stuck_and_gaps;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        idle(1);
        send(4'h0);
        checks++;
        if ({stuck_zero, locked} !== 2'b10) begin errors++; $display("FAIL stuck_set: stuck=%b locked=%b want 1 0", stuck_zero, locked); end
        send(4'h1);
        idle(3);
        send(4'h8);
        idle(2);
        send(4'h4);
        send(4'h2);
        idle(4);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL gaps_early: locked got %b want 0", locked); end
        send(4'h9);
        checks++;
        if ({locked, stuck_zero} !== 2'b11) begin errors++; $display("FAIL gaps_lock: locked=%b stuck=%b want 1 1", locked, stuck_zero); end
        idx = 4;
    endtask

    task automatic test_saturation;
        for (int r = 0; r < 127; r++) begin
            idx = (idx + 1) % 15; send(4'h0);
            idx = (idx + 1) % 15; send(4'h0);
            idx = (idx + 1) % 15; send(seq[idx]);
        end
        checks++;
        if ({err_cnt, locked} !== {8'd254, 1'b1}) begin errors++; $display("FAIL sat_254: err=%0d locked=%b want 254 1", err_cnt, locked); end
        idx = (idx + 1) % 15; send(4'h0);
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", err_cnt); end
        idx = (idx + 1) % 15; send(seq[idx]);
        idx = (idx + 1) % 15; send(4'h0);
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
        idx = (idx + 1) % 15; send(seq[idx]);
    endtask

    task automatic test_err_clr;
        err_clr = 1'b1;
        idx = (idx + 1) % 15; send(4'h0);
        err_clr = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_vs_miss: got %0d want 0", err_cnt); end
        idx = (idx + 1) % 15; send(seq[idx]);
        idx = (idx + 1) % 15; send(4'h0);
        checks++;
        if (err_cnt !== 8'd1) begin errors++; $display("FAIL clr_recount: got %0d want 1", err_cnt); end
        idx = (idx + 1) % 15; send(seq[idx]);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        checks++;
        if ({err_cnt, locked} !== {8'd0, 1'b1}) begin errors++; $display("FAIL clr_idle: err=%0d locked=%b want 0 1", err_cnt, locked); end
    endtask

    task automatic test_async_reset;
        idx = (idx + 1) % 15; send(4'h0);
        checks++;
        if ({locked, err_cnt, stuck_zero} !== {1'b1, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: locked=%b err=%0d stuck=%b want 1 1 1", locked, err_cnt, stuck_zero);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({locked, lost, stuck_zero, err_cnt, period, period_valid, expected} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset: got %b want 0", {locked, lost, stuck_zero, err_cnt, period, period_valid, expected});
        end
        reset = 1'b1;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_period();
        test_flywheel();
        test_loss();
        test_stuck_and_gaps();
        test_saturation();
        test_err_clr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream monitor for the 4-bit feedback shift counter. Consumes its 4-bit state each sampled cycle and checks it against the counter's recurrence.
- Recurrence: next(q) = {q[0]^q[1], q[3], q[2], q[1]}. This is maximal length: the 15 nonzero states form one cycle, and 0000 is a lock-up state.
- Acquires lock, flywheels through errors, declares loss of lock, counts errors, measures sequence period and flags the all-zero lock-up.

Parameters:
- LOCK_COUNT, 4, consecutive matching samples needed to declare lock (range 1..15)
- LOSS_COUNT, 3, consecutive mismatches in LOCKED needed to declare loss (range 1..15)
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- data_in  input  4  counter state being monitored
- valid  input  1  data_in is a sample this cycle; all state advances only on valid=1 (LOST exit excepted)
- err_clr  input  1  synchronous clear of err_cnt
- expected  output  4  next(ref), combinational from the ref register
- locked  output  1  1 while the FSM is in LOCKED
- lost  output  1  one-cycle pulse on the LOCKED->LOST transition
- stuck_zero  output  1  sticky; set when a valid sample equals 0000 outside LOCKED
- err_cnt  output  ERR_W  saturating count of mismatches seen in LOCKED
- period  output  5  last measured sequence length
- period_valid  output  1  one-cycle pulse when period updates

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; ref, match_cnt, miss_cnt, per_cnt, anchor = 0.
  - Outputs: locked=0, lost=0, stuck_zero=0, err_cnt=0, period=0, period_valid=0.
  - expected = next(0000) = 0000.
- Reset mid-operation aborts everything immediately. No state survives.
- FSM: IDLE(0), SYNC(1), LOCKED(2), LOST(3). Every transition below takes effect at the clock edge of the valid cycle, unless stated otherwise.
- IDLE, on valid:
  - data_in==0: set stuck_zero, stay IDLE.
  - Otherwise: ref<=data_in, match_cnt<=0, go to SYNC.
- SYNC, on valid:
  - data_in==0: set stuck_zero, go to IDLE.
  - data_in==next(ref): ref<=data_in, match_cnt+1. When this is match number LOCK_COUNT, go to LOCKED. locked rises the cycle after the edge that accepts that match.
  - Lock entry also sets anchor<=data_in, per_cnt<=0, miss_cnt<=0.
  - Other mismatch: ref<=data_in, match_cnt<=0, stay SYNC (re-seed).
- LOCKED, on valid:
  - Match: ref<=data_in, miss_cnt<=0.
  - Mismatch (including 0000): err_cnt+1, saturating at all-ones. ref<=next(ref), i.e. flywheel and ignore the bad sample. miss_cnt+1.
  - When miss_cnt reaches LOSS_COUNT, go to LOST and pulse lost=1 for the cycle after that edge.
  - stuck_zero is not set in LOCKED.
- LOST: lasts exactly one cycle, then goes to IDLE regardless of valid. A sample arriving in this cycle is dropped.
- Period measurement (LOCKED only):
  - Each valid sample increments per_cnt, saturating at 31.
  - On a matching sample with data_in==anchor: period<=per_cnt+1 (saturating at 31), period_valid=1 for one cycle, per_cnt<=0.
  - A correct stream therefore gives period=15.
  - Mismatch samples increment per_cnt but never close a period.
- err_clr: clears err_cnt at the next edge. If a mismatch occurs in the same cycle, the clear wins and err_cnt=0.
- valid=0: no register changes, except the LOST->IDLE exit and err_clr.
- Registered outputs, no combinational path from inputs to outputs (expected depends only on ref).

Test Plan:
- Reset released, valid stream starting 0001,1000,0100,0010,1001 -> SYNC after 0001. locked=1 the cycle after 1001 is accepted (4 matches). expected=1100 after 1001.
- Locked and fed the full correct cycle 0001..0011 repeatedly -> period=15 with a period_valid pulse every 15 valid samples. err_cnt stays 0.
- Locked, one corrupted sample (0110 replaced by 0000), then correct stream resumes -> err_cnt=1, locked stays 1, stuck_zero stays 0, next correct sample 1011 matches via flywheel.
- Locked, 3 consecutive garbage samples -> lost pulses once, state goes LOST then IDLE, locked=0. The following sample 1010 re-enters SYNC.
- From IDLE, data_in=0000 with valid -> stuck_zero=1 and stays 1 until reset. Gaps with valid=0 inserted mid-SYNC -> lock timing counts only valid samples.
- err_cnt driven to 255 with ERR_W=8 -> stays 255 on further errors. err_clr asserted together with a mismatch -> err_cnt=0. reset=0 asserted mid-LOCKED -> all outputs 0 without waiting for a clock edge.
